// File: rtl/jk_counter_bank.sv
// WIDTH-bit bank of JK cells. Each edge it acts as a per-bit JK register,
// an up/down counter (wrapping or saturating) or a parallel load.

module jk_cell (
  input  logic i_j,
  input  logic i_k,
  input  logic i_q,
  output logic o_q_nxt
);
  always_comb begin
    o_q_nxt = i_q;
    case ({i_j, i_k})
      2'b01:   o_q_nxt = 1'b0;
      2'b10:   o_q_nxt = 1'b1;
      2'b11:   o_q_nxt = ~i_q;
      default: o_q_nxt = i_q;
    endcase
  end
endmodule

module jk_counter_bank #(
  parameter int               WIDTH        = 4,
  parameter logic [WIDTH-1:0] PRESET_VALUE = '1,
  parameter bit               WRAP         = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             PRESET,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  input  logic             CLR_OVF,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             TC,
  output logic             OVF,
  output logic             CHG
);
  localparam logic [1:0] M_JK = 2'b00, M_UP = 2'b01, M_DN = 2'b10, M_LD = 2'b11;

  logic [WIDTH-1:0] r_q, w_jk_nxt, w_q_nxt;
  logic             r_ovf, r_chg, w_ovf_set, w_all1, w_zero;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
        .i_j     (J[gi]),
        .i_k     (K[gi]),
        .i_q     (r_q[gi]),
        .o_q_nxt (w_jk_nxt[gi])
      );
    end
  endgenerate

  assign w_all1 = &r_q;
  assign w_zero = ~|r_q;

  // Boundary counts raise OVF whether they wrap or saturate.
  always_comb begin
    w_q_nxt   = r_q;
    w_ovf_set = 1'b0;
    if (PRESET) begin
      w_q_nxt = PRESET_VALUE;
    end else if (EN) begin
      case (MODE)
        M_JK: w_q_nxt = w_jk_nxt;
        M_UP: begin
          if (w_all1) begin
            w_ovf_set = 1'b1;
            w_q_nxt   = WRAP ? '0 : r_q;
          end else begin
            w_q_nxt = r_q + WIDTH'(1);
          end
        end
        M_DN: begin
          if (w_zero) begin
            w_ovf_set = 1'b1;
            w_q_nxt   = WRAP ? '1 : r_q;
          end else begin
            w_q_nxt = r_q - WIDTH'(1);
          end
        end
        M_LD: w_q_nxt = D;
        default: w_q_nxt = r_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
      r_chg <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_chg <= (w_q_nxt != r_q);
      r_ovf <= w_ovf_set | (r_ovf & ~CLR_OVF);
    end
  end

  assign Q   = r_q;
  assign Qn  = ~r_q;
  assign OVF = r_ovf;
  assign CHG = r_chg;
  assign TC  = ((MODE == M_UP) && w_all1) || ((MODE == M_DN) && w_zero);
endmodule

// File: tb/tb_jk_counter_bank.sv
// Directed bench: a wrapping and a saturating 4-bit bank share stimulus;
// expected outputs are queued per step and checked after the edge.

module tb_jk_counter_bank;
  logic       CLK = 1'b0;
  logic       RESET, PRESET, EN, CLR_OVF;
  logic [1:0] MODE;
  logic [3:0] J, K, D;
  logic [3:0] q0, qn0, q1, qn1;
  logic       tc0, ovf0, chg0, tc1, ovf1, chg1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [3:0] q0;  logic ovf0; logic chg0; logic tc0;
    logic [3:0] q1;  logic ovf1; logic chg1; logic tc1;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  jk_counter_bank #(.WIDTH(4), .WRAP(1'b1)) u_wrap (
    .CLK(CLK), .RESET(RESET), .PRESET(PRESET), .EN(EN), .MODE(MODE),
    .J(J), .K(K), .D(D), .CLR_OVF(CLR_OVF),
    .Q(q0), .Qn(qn0), .TC(tc0), .OVF(ovf0), .CHG(chg0)
  );

  jk_counter_bank #(.WIDTH(4), .WRAP(1'b0)) u_sat (
    .CLK(CLK), .RESET(RESET), .PRESET(PRESET), .EN(EN), .MODE(MODE),
    .J(J), .K(K), .D(D), .CLR_OVF(CLR_OVF),
    .Q(q1), .Qn(qn1), .TC(tc1), .OVF(ovf1), .CHG(chg1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push the expectation, take one edge, then pop and compare.
  task automatic step(input string tag,
                      input logic [3:0] eq0, input logic eo0, input logic ec0, input logic et0,
                      input logic [3:0] eq1, input logic eo1, input logic ec1, input logic et1);
    exp_t e;
    e.tag = tag;
    e.q0 = eq0; e.ovf0 = eo0; e.chg0 = ec0; e.tc0 = et0;
    e.q1 = eq1; e.ovf1 = eo1; e.chg1 = ec1; e.tc1 = et1;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".wrap.Q"},   {28'd0, q0},  {28'd0, e.q0});
    chk({e.tag, ".wrap.Qn"},  {28'd0, qn0}, {28'd0, ~e.q0});
    chk({e.tag, ".wrap.OVF"}, {31'd0, ovf0}, {31'd0, e.ovf0});
    chk({e.tag, ".wrap.CHG"}, {31'd0, chg0}, {31'd0, e.chg0});
    chk({e.tag, ".wrap.TC"},  {31'd0, tc0},  {31'd0, e.tc0});
    chk({e.tag, ".sat.Q"},    {28'd0, q1},  {28'd0, e.q1});
    chk({e.tag, ".sat.Qn"},   {28'd0, qn1}, {28'd0, ~e.q1});
    chk({e.tag, ".sat.OVF"},  {31'd0, ovf1}, {31'd0, e.ovf1});
    chk({e.tag, ".sat.CHG"},  {31'd0, chg1}, {31'd0, e.chg1});
    chk({e.tag, ".sat.TC"},   {31'd0, tc1},  {31'd0, e.tc1});
  endtask

  initial begin
    RESET = 1'b1; PRESET = 1'b0; EN = 1'b0; CLR_OVF = 1'b0;
    MODE = 2'b00; J = 4'h0; K = 4'h0; D = 4'h0;

    //         tag         q0    o  c  t     q1    o  c  t
    step("rst1",          4'h0, 0, 0, 0,   4'h0, 0, 0, 0);
    step("rst2",          4'h0, 0, 0, 0,   4'h0, 0, 0, 0);
    RESET = 1'b0; PRESET = 1'b1;
    step("preset",        4'hF, 0, 1, 0,   4'hF, 0, 1, 0);
    PRESET = 1'b0; EN = 1'b1; MODE = 2'b11; D = 4'hA;
    step("load_a",        4'hA, 0, 1, 0,   4'hA, 0, 1, 0);
    MODE = 2'b00; J = 4'b0011; K = 4'b0101;
    step("jk_mix",        4'hB, 0, 1, 0,   4'hB, 0, 1, 0);
    J = 4'h0; K = 4'h0;
    step("jk_hold",       4'hB, 0, 0, 0,   4'hB, 0, 0, 0);
    MODE = 2'b11; D = 4'hE;
    step("load_e",        4'hE, 0, 1, 0,   4'hE, 0, 1, 0);
    MODE = 2'b01;
    step("up1",           4'hF, 0, 1, 1,   4'hF, 0, 1, 1);
    step("up2",           4'h0, 1, 1, 0,   4'hF, 1, 0, 1);
    step("up3",           4'h1, 1, 1, 0,   4'hF, 1, 0, 1);
    EN = 1'b0;
    step("en0_hold",      4'h1, 1, 0, 0,   4'hF, 1, 0, 1);
    CLR_OVF = 1'b1;
    step("clr_ovf",       4'h1, 0, 0, 0,   4'hF, 0, 0, 1);
    CLR_OVF = 1'b0; EN = 1'b1; MODE = 2'b11; D = 4'h1;
    step("load_1",        4'h1, 0, 0, 0,   4'h1, 0, 1, 0);
    MODE = 2'b10;
    step("dn1",           4'h0, 0, 1, 1,   4'h0, 0, 1, 1);
    step("dn2",           4'hF, 1, 1, 0,   4'h0, 1, 0, 1);
    step("dn3",           4'hE, 1, 1, 0,   4'h0, 1, 0, 1);
    MODE = 2'b11; D = 4'hF; CLR_OVF = 1'b1;
    step("load_f_clr",    4'hF, 0, 1, 0,   4'hF, 0, 1, 0);
    MODE = 2'b01;
    step("set_wins",      4'h0, 1, 1, 0,   4'hF, 1, 0, 1);
    EN = 1'b0;
    step("en0_clr",       4'h0, 0, 0, 0,   4'hF, 0, 0, 1);
    EN = 1'b1; CLR_OVF = 1'b0;
    step("count_a",       4'h1, 0, 1, 0,   4'hF, 1, 0, 1);
    step("count_b",       4'h2, 0, 1, 0,   4'hF, 1, 0, 1);
    RESET = 1'b1; PRESET = 1'b1;
    step("rst_and_pre",   4'h0, 0, 0, 0,   4'h0, 0, 0, 0);
    MODE = 2'b10;
    step("rst_tc_live",   4'h0, 0, 0, 1,   4'h0, 0, 0, 1);
    RESET = 1'b0; MODE = 2'b01;
    step("pre_after_rst", 4'hF, 0, 1, 1,   4'hF, 0, 1, 1);
    MODE = 2'b10;
    step("pre_nochg",     4'hF, 0, 0, 0,   4'hF, 0, 0, 0);
    PRESET = 1'b0; MODE = 2'b01;
    step("restart_up",    4'h0, 1, 1, 0,   4'hF, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
